// File: rtl/hazard_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_pkg: scoreboard entry layout and forwarding constants         |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package hazard_pkg;

   // Entry bit layout: {rd, ld, wr, valid}
   localparam int E_VALID = 0;
   localparam int E_WR    = 1;
   localparam int E_LD    = 2;
   localparam int E_RD    = 3;

   localparam int FWD_RF  = 0;

   function automatic int calc_sel_w(input int num_stages);
      return $clog2(num_stages + 1);
   endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_match_prio.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | hazard_match_prio: youngest-producer select and load-not-ready flag  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module hazard_match_prio
   import hazard_pkg::*;
#(
   parameter int NUM_STAGES = 3,
   parameter int REG_W      = 5,
   parameter int LOAD_READY = 2,
   parameter int SEL_W      = 2
)(
   input  logic                                src_used,
   input  logic [REG_W-1:0]                    src,
   input  logic [NUM_STAGES*(REG_W+E_RD)-1:0]  entries,
   output logic [SEL_W-1:0]                    sel,
   output logic                                load_hazard
);

   localparam int c_ent_w = REG_W + E_RD;

   always_comb begin
      sel         = SEL_W'(FWD_RF);
      load_hazard = 1'b0;
      // Scan oldest first so the youngest matching producer wins
      for (int k = NUM_STAGES; k >= 1; k--) begin
         if (src_used && (src != '0) &&
             entries[(k-1)*c_ent_w + E_VALID] &&
             entries[(k-1)*c_ent_w + E_WR] &&
             (entries[(k-1)*c_ent_w + E_RD +: REG_W] == src)) begin
            sel         = SEL_W'(k);
            load_hazard = entries[(k-1)*c_ent_w + E_LD] && (k < LOAD_READY);
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pipeline_hazard_ctrl: shadow scoreboard, forwarding and load-use stall|
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module pipeline_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int NUM_SRC    = 3,
   parameter int NUM_STAGES = 3,
   parameter int REG_W      = 5,
   parameter int LOAD_READY = 2,
   parameter int CNT_W      = 16,
   localparam int SEL_W     = calc_sel_w(NUM_STAGES)
)(
   input  logic                       Clk,
   input  logic                       R,
   input  logic                       id_valid,
   input  logic                       id_rf_enable,
   input  logic                       id_load,
   input  logic [REG_W-1:0]           id_rd,
   input  logic [NUM_SRC*REG_W-1:0]   id_src,
   input  logic [NUM_SRC-1:0]         id_src_used,
   input  logic                       flush,
   output logic [NUM_SRC*SEL_W-1:0]   fwd_sel,
   output logic                       stall,
   output logic                       pc_npc_enable,
   output logic                       if_id_enable,
   output logic                       nop_sel,
   output logic [NUM_STAGES-1:0]      stage_valid,
   output logic [CNT_W-1:0]           stall_count,
   output logic [CNT_W-1:0]           flush_count
);

   localparam int               c_ent_w   = REG_W + E_RD;
   localparam logic [CNT_W-1:0] c_cnt_max = '1;

   logic [NUM_STAGES*c_ent_w-1:0] r_sb;
   logic [c_ent_w-1:0]            w_new;
   logic [NUM_SRC-1:0]            w_hz;
   logic                          w_stall;
   logic [CNT_W-1:0]              r_stall_cnt;
   logic [CNT_W-1:0]              r_flush_cnt;

   generate
      if (LOAD_READY < 1 || LOAD_READY > NUM_STAGES) begin : g_bad_load_ready
         $error("pipeline_hazard_ctrl: LOAD_READY must lie in 1..NUM_STAGES");
      end
   endgenerate

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
         hazard_match_prio #(
            .NUM_STAGES (NUM_STAGES),
            .REG_W      (REG_W),
            .LOAD_READY (LOAD_READY),
            .SEL_W      (SEL_W)
         ) u_match (
            .src_used    (id_src_used[i]),
            .src         (id_src[i*REG_W +: REG_W]),
            .entries     (r_sb),
            .sel         (fwd_sel[i*SEL_W +: SEL_W]),
            .load_hazard (w_hz[i])
         );
      end
   endgenerate

   // Flush overrides the stall; the killed instruction becomes a bubble
   assign w_stall = id_valid & ~flush & (|w_hz);
   assign w_new   = (id_valid & ~w_stall & ~flush) ?
                    {id_rd, id_load, id_rf_enable, 1'b1} : '0;

   generate
      if (NUM_STAGES > 1) begin : g_shift
         always_ff @(posedge Clk or posedge R) begin
            if (R) r_sb <= '0;
            else   r_sb <= {r_sb[(NUM_STAGES-1)*c_ent_w-1:0], w_new};
         end
      end else begin : g_single
         always_ff @(posedge Clk or posedge R) begin
            if (R) r_sb <= '0;
            else   r_sb <= w_new;
         end
      end
   endgenerate

   generate
      for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage_valid
         assign stage_valid[k] = r_sb[k*c_ent_w + E_VALID];
      end
   endgenerate

   always_ff @(posedge Clk or posedge R) begin
      if (R) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && (r_stall_cnt != c_cnt_max)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (flush   && (r_flush_cnt != c_cnt_max)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall         = w_stall;
   assign pc_npc_enable = ~w_stall;
   assign if_id_enable  = ~w_stall;
   assign nop_sel       = w_stall | flush;
   assign stall_count   = r_stall_cnt;
   assign flush_count   = r_flush_cnt;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Parametrised hazard and forwarding controller for the in-order SPARC-subset pipeline. It succeeds the fixed 3-source, 3-stage hazard unit.
- Keeps its own shadow scoreboard of destination registers in flight across NUM_STAGES post-ID stages (default EX/MEM/WB).
- Drives per-source forwarding selects, load-use stall, PC/nPC and IF/ID enables, and the control-NOP select.
- Accepts a flush from branch/jmpl resolution.
- Keeps saturating stall and flush statistics counters.

Parameters:
- NUM_SRC, 3, number of source-operand ports checked (RA, RB, RD-as-store-data).
- NUM_STAGES, 3, post-ID stages tracked; stage 1 = EX, stage NUM_STAGES = WB.
- REG_W, 5, register address width.
- LOAD_READY, 2, first stage index whose result bus carries load data. Legal range is 1..NUM_STAGES; an out-of-range value is an elaboration error.
- CNT_W, 16, statistics counter width.
- SEL_W, $clog2(NUM_STAGES+1), forwarding select width (derived localparam).

Ports:
- Clk, input, 1, clock; all state updates on its rising edge.
- R, input, 1, asynchronous active-high reset.
- id_valid, input, 1, ID stage holds a real instruction.
- id_rf_enable, input, 1, ID instruction writes the register file.
- id_load, input, 1, ID instruction is a load.
- id_rd, input, REG_W, ID destination register (already muxed to r15 for call).
- id_src, input, NUM_SRC*REG_W, source register addresses; source i occupies slice [i*REG_W +: REG_W].
- id_src_used, input, NUM_SRC, source i is actually read.
- flush, input, 1, kill the ID instruction this cycle (taken branch / jmpl / annul).
- fwd_sel, output, NUM_SRC*SEL_W, per-source select; 0 = register file, k = stage-k result.
- stall, output, 1, load-use stall active.
- pc_npc_enable, output, 1, PC/nPC load enable.
- if_id_enable, output, 1, IF/ID register load enable.
- nop_sel, output, 1, select NOP in the control-signal mux.
- stage_valid, output, NUM_STAGES, valid bit of each scoreboard entry.
- stall_count, output, CNT_W, number of stall cycles, saturating.
- flush_count, output, CNT_W, number of flush cycles, saturating.

Behaviour:
- Scoreboard: NUM_STAGES entries of {valid, wr, ld, rd}, entry k mirroring stage k.
- Every rising edge: entry k <= entry k-1 for k >= 2.
- Entry 1 <= {1, id_rf_enable, id_load, id_rd} when id_valid & !stall & !flush; otherwise entry 1 <= bubble (all fields 0).
- Match(i,k) = id_src_used[i] & id_src_i != 0 & entry k valid & wr & rd == id_src_i. r0 (%g0) never matches.
- Forwarding priority: fwd_sel_i = smallest k with Match(i,k), i.e. youngest producer wins; 0 if no match.
- Combinational from scoreboard and ID inputs; zero latency.
- Load-use: hazard_i is set when the youngest match for source i has ld=1 and k < LOAD_READY.
- stall = id_valid & !flush & OR over i of hazard_i.
- A non-load match younger than a load match suppresses the stall for that source.
- Output rules:
  - pc_npc_enable = if_id_enable = !stall.
  - nop_sel = stall | flush.
  - fwd_sel stays computed during a stall. It is ignored downstream because a bubble is injected.
- Flush and stall raised together: flush wins, stall = 0, a bubble is injected and both enables stay 1.
- Stall is self-clearing: the load advances one stage per cycle. With LOAD_READY=2 a dependent instruction stalls exactly 1 cycle; with LOAD_READY=L the worst case is L-1 cycles.
- Counters:
  - stall_count increments on each cycle with stall=1; flush_count on each cycle with flush=1.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (asserted at any time, including mid-stall):
  - Immediately clears all entries to invalid and both counters to 0.
  - Outputs then read fwd_sel=0, stall=0, pc_npc_enable=1, if_id_enable=1, nop_sel=flush, stage_valid=0.
- Inputs are sampled only at the rising edge; no combinational path from flush into the scoreboard except through the entry-1 bubble rule.

Decomposition:
- Shared package hazard_pkg holds:
  - entry field offsets (VALID, WR, LD, RD);
  - FWD_RF=0;
  - the constant function computing SEL_W.
- One sub-module, hazard_match_prio, is instantiated NUM_SRC times. Per source it:
  - compares against all entries;
  - emits the youngest-match index and the load-not-ready flag.
- Scoreboard shift, stall/flush logic and counters remain in the top module.

Test Plan:
1. add r3 then add r5,r3,r3 back-to-back → fwd_sel for RA and RB = 1 (EX); next instruction reading r3 → 2; two instructions later → 3; after that → 0.
2. ld r8 then add r9,r8,r1 (LOAD_READY=2) → stall=1 for exactly 1 cycle with pc_npc_enable=0 and nop_sel=1; next cycle fwd_sel_RA=2, stall=0, stall_count=1.
3. ld r8, then add r8,..., then a reader of r8 → youngest (non-load) producer in EX is selected, fwd_sel=1, no stall.
4. Any source = r0 with an in-flight writer to r0 → fwd_sel=0, stall=0.
5. Load-use hazard coinciding with flush=1 → stall=0, entry 1 bubble, flush_count+1; R asserted mid-stall at a non-edge time → stage_valid=0 and counters=0 immediately.
6. NUM_STAGES=5, LOAD_READY=4: load followed by dependent → 3 stall cycles, then fwd_sel=4; drive 65540 stall cycles with CNT_W=16 → stall_count holds 65535.
